// File: rtl/pipe_stage_skid_reg.sv
// Elastic pipeline-stage register with 2-entry skid: 1-cycle latency, up_ready driven only from flops.
// Define PIPE_PERF_CNT_EN to add the saturating stall/bubble/flush performance counters.
module pipe_stage_skid_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16
`ifdef PIPE_PERF_CNT_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  input  logic [CTRL_W-1:0] up_ctrl,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data,
  output logic [CTRL_W-1:0] dn_ctrl
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  // Encoding is {main_valid, skid_valid}; 01 never occurs.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic                in_fire, out_fire;

  assign up_ready = ~state_q[0];
  assign dn_valid = state_q[1];
  assign dn_data  = main_data_q;
  assign dn_ctrl  = main_ctrl_q;
  assign in_fire  = up_valid & up_ready;
  assign out_fire = dn_valid & dn_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      // An entry accepted alongside the flush is dropped; any out_fire already happened.
      state_d     = EMPTY;
      main_data_d = '0;
      main_ctrl_d = '0;
      skid_data_d = '0;
      skid_ctrl_d = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d     = ONE;
            main_data_d = up_data;
            main_ctrl_d = up_ctrl;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_data_d = up_data;
            main_ctrl_d = up_ctrl;
          end else if (in_fire) begin
            state_d     = FULL;
            skid_data_d = up_data;
            skid_ctrl_d = up_ctrl;
          end else if (out_fire) begin
            state_d     = EMPTY;
            main_data_d = '0;
            main_ctrl_d = '0;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d     = ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            skid_data_d = '0;
            skid_ctrl_d = '0;
          end
        end
        default: begin
          state_d     = EMPTY;
          main_data_d = '0;
          main_ctrl_d = '0;
          skid_data_d = '0;
          skid_ctrl_d = '0;
        end
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Each counter holds at all-ones once saturated; only reset clears them.
  assign stall_cnt_d  = (dn_valid && !dn_ready && stall_cnt_q != '1) ? stall_cnt_q + CNT_ONE : stall_cnt_q;
  assign bubble_cnt_d = (!dn_valid && bubble_cnt_q != '1) ? bubble_cnt_q + CNT_ONE : bubble_cnt_q;
  assign flush_cnt_d  = (flush && flush_cnt_q != '1) ? flush_cnt_q + CNT_ONE : flush_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Scoreboard bench for pipe_stage_skid_reg: occupancy model plus queue of expected outputs.
module tb_pipe_stage_skid_reg;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int NW = 2;

  logic          clk = 1'b0;
  logic          reset, flush, up_valid, up_ready, dn_valid, dn_ready;
  logic [DW-1:0] up_data, dn_data;
  logic [CW-1:0] up_ctrl, dn_ctrl;
`ifdef PIPE_PERF_CNT_EN
  logic [NW-1:0] stall_cnt, bubble_cnt, flush_cnt;
  int            m_stall, m_bubble, m_flush;
`endif

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  ent_t exp_q[$];
  int   occ;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pipe_stage_skid_reg #(
    .DATA_W(DW),
    .CTRL_W(CW)
`ifdef PIPE_PERF_CNT_EN
    ,
    .CNT_W(NW)
`endif
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data), .up_ctrl(up_ctrl),
    .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_data(dn_data), .dn_ctrl(dn_ctrl)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  // Reference model: the stage is a FIFO of depth 2 whose ready reflects last cycle's occupancy.
  always @(posedge clk or posedge reset) begin : model
    bit inf, outf;
    if (reset) begin
      occ = 0;
      exp_q.delete();
`ifdef PIPE_PERF_CNT_EN
      m_stall = 0; m_bubble = 0; m_flush = 0;
`endif
    end else begin
      inf  = up_valid && (occ < 2);
      outf = (occ > 0) && dn_ready;
`ifdef PIPE_PERF_CNT_EN
      if (occ > 0 && !dn_ready && m_stall < 3) m_stall++;
      if (occ == 0 && m_bubble < 3) m_bubble++;
      if (flush && m_flush < 3) m_flush++;
`endif
      if (flush) begin
        occ = 0;
        exp_q.delete();
      end else begin
        if (outf) occ--;
        if (inf) begin
          exp_q.push_back('{d: up_data, c: up_ctrl});
          occ++;
        end
      end
    end
  end

  // Monitor: compares handshake state every cycle and pops on each downstream transfer.
  always @(negedge clk) begin : monitor
    ent_t e;
    if (!reset) begin
      chk("up_ready", 64'(up_ready), 64'(occ < 2));
      chk("dn_valid", 64'(dn_valid), 64'(occ > 0));
      if (occ == 0) begin
        chk("idle_data", 64'(dn_data), 64'd0);
        chk("idle_ctrl", 64'(dn_ctrl), 64'd0);
      end else if (exp_q.size() > 0) begin
        e = dn_ready ? exp_q.pop_front() : exp_q[0];
        chk(dn_ready ? "out_data" : "hold_data", 64'(dn_data), 64'(e.d));
        chk(dn_ready ? "out_ctrl" : "hold_ctrl", 64'(dn_ctrl), 64'(e.c));
      end
`ifdef PIPE_PERF_CNT_EN
      chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      chk("bubble_cnt", 64'(bubble_cnt), 64'(m_bubble));
      chk("flush_cnt", 64'(flush_cnt), 64'(m_flush));
`endif
    end
  end

  task automatic step(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                      input logic r, input logic f);
    up_valid = v; up_data = d; up_ctrl = c; dn_ready = r; flush = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; flush = 1'b0; up_valid = 1'b0; dn_ready = 1'b0; up_data = '0; up_ctrl = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_up_ready", 64'(up_ready), 64'd1);
    chk("rst_dn_valid", 64'(dn_valid), 64'd0);
    chk("rst_dn_data", 64'(dn_data), 64'd0);
    chk("rst_dn_ctrl", 64'(dn_ctrl), 64'd0);
    reset = 1'b0;

    // Back-to-back stream with an always-ready sink.
    for (int i = 0; i < 16; i++) step(1'b1, 32'h10 + 32'(i), 16'(i), 1'b1, 1'b0);
    repeat (2) step(1'b0, '0, '0, 1'b1, 1'b0);

    // Fill the skid slot, hold, then drain.
    step(1'b1, 32'hA0, 16'h00A0, 1'b1, 1'b0);
    step(1'b1, 32'hA1, 16'h00A1, 1'b0, 1'b0);
    repeat (3) step(1'b1, 32'hDEAD, 16'h0BAD, 1'b0, 1'b0);
    repeat (3) step(1'b0, '0, '0, 1'b1, 1'b0);

    // Flush from FULL.
    step(1'b1, 32'hB0, 16'h00B0, 1'b0, 1'b0);
    step(1'b1, 32'hB1, 16'h00B1, 1'b0, 1'b0);
    step(1'b1, 32'hB2, 16'h00B2, 1'b0, 1'b1);
    repeat (2) step(1'b0, '0, '0, 1'b1, 1'b0);

    // All-ones control must vanish once the entry drains.
    step(1'b1, 32'hC0, 16'hFFFF, 1'b1, 1'b0);
    repeat (2) step(1'b0, '0, '0, 1'b1, 1'b0);

    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 3) != 0, $urandom, 16'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 24) == 0);

    // Asynchronous reset between clock edges while the stage is busy.
    repeat (4) step(1'b1, $urandom, 16'hFFFF, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("arst_dn_valid", 64'(dn_valid), 64'd0);
    chk("arst_dn_ctrl", 64'(dn_ctrl), 64'd0);
    chk("arst_up_ready", 64'(up_ready), 64'd1);
    up_valid = 1'b0; dn_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) step(1'b0, '0, '0, 1'b1, 1'b0);

    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 1) != 0, $urandom, 16'($urandom), $urandom_range(0, 2) != 0,
           $urandom_range(0, 15) == 0);
    repeat (3) step(1'b0, '0, '0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
